// File: rtl/bgpu_reg_arbiter.sv
// Round-robin arbiter that shares one register-interface target among NumReq requesters, one transaction in flight.
// Optional watchdog is enabled by defining BGPU_REG_ARB_TIMEOUT_EN.
module bgpu_reg_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  input  logic [NumReq*AddrWidth-1:0]        req_addr_i,
  input  logic [NumReq-1:0]                  req_write_i,
  input  logic [NumReq*DataWidth-1:0]        req_wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0]    req_wstrb_i,
  output logic [NumReq-1:0]                  req_ready_o,
  output logic [DataWidth-1:0]               req_rdata_o,
  output logic                               req_error_o,
  output logic                               mst_valid_o,
  output logic [AddrWidth-1:0]               mst_addr_o,
  output logic                               mst_write_o,
  output logic [DataWidth-1:0]               mst_wdata_o,
  output logic [DataWidth/8-1:0]             mst_wstrb_o,
  input  logic                               mst_ready_i,
  input  logic [DataWidth-1:0]               mst_rdata_i,
  input  logic                               mst_error_i,
  output logic                               busy_o,
  output logic [$clog2(NumReq)-1:0]          grant_idx_o
);

  localparam int unsigned IdxWidth  = $clog2(NumReq);
  localparam int unsigned StrbWidth = DataWidth / 8;

  if ((NumReq < 2) || (TimeoutCycles < 1)) begin : g_bad_param
    $error("bgpu_reg_arbiter: NumReq must be >= 2 and TimeoutCycles >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] grant_q, grant_d;
  logic [IdxWidth-1:0] last_q, last_d;
  logic [IdxWidth-1:0] rr_idx;
  logic                rr_found;
  logic                timeout;

`ifdef BGPU_REG_ARB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] wd_cnt_q;

  assign timeout = (state_q == BUSY) && (wd_cnt_q == CntWidth'(TimeoutCycles));

  // Clearing throughout IDLE guarantees a fresh count on every BUSY entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      wd_cnt_q <= '0;
    end else if (!mst_ready_i && !timeout) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search: indices above last_q first, then wrap to the lower ones.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!rr_found && req_valid_i[i] && (IdxWidth'(i) > last_q)) begin
        rr_found = 1'b1;
        rr_idx   = IdxWidth'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!rr_found && req_valid_i[i] && (IdxWidth'(i) <= last_q)) begin
        rr_found = 1'b1;
        rr_idx   = IdxWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IdxWidth'(NumReq - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    req_ready_o = '0;
    req_rdata_o = '0;
    req_error_o = 1'b0;
    mst_valid_o = 1'b0;
    mst_addr_o  = '0;
    mst_write_o = 1'b0;
    mst_wdata_o = '0;
    mst_wstrb_o = '0;
    busy_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_o      = 1'b1;
        mst_valid_o = req_valid_i[grant_q] && !timeout;
        mst_addr_o  = req_addr_i[grant_q*AddrWidth +: AddrWidth];
        mst_write_o = req_write_i[grant_q];
        mst_wdata_o = req_wdata_i[grant_q*DataWidth +: DataWidth];
        mst_wstrb_o = req_wstrb_i[grant_q*StrbWidth +: StrbWidth];
        if (timeout) begin
          // Synthesised error completion so a dead target cannot lock out requesters.
          req_ready_o[grant_q] = 1'b1;
          req_rdata_o          = '1;
          req_error_o          = 1'b1;
          last_d               = grant_q;
          state_d              = IDLE;
        end else begin
          req_ready_o[grant_q] = mst_ready_i;
          req_rdata_o          = mst_rdata_i;
          req_error_o          = mst_error_i;
          if (mst_ready_i) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_idx_o = grant_q;

endmodule
